// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory and releases cpu reset after a checksum-verified frame
module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);
  localparam int IW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt;
  logic [23:0] sh;
  logic [31:0] word;
  logic [IW-1:0] n, idx;
  logic acc, last;
  assign byte_ready = !rst && (state == HDR || state == DATA || state == CSUM);
  assign acc = byte_valid && byte_ready;
  assign last = acc && cnt == 2'd3;
  assign word = {byte_data, sh};
  always_comb begin
    state_nxt = !last ? state :
                state == HDR  ? (word > 32'(DEPTH) ? ERR : word == '0 ? CSUM : DATA) :
                state == DATA ? (idx == n - IW'(1) ? CSUM : DATA) :
                state == CSUM ? (word == checksum ? DONE : ERR) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      cnt <= '0;
      sh <= '0;
      n <= '0;
      idx <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      checksum <= '0;
      done <= 1'b0;
      error <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= state_nxt != state ? 2'd0 : cnt + 2'(acc);
      if (acc) sh <= {byte_data, sh[23:8]};
      wr_en <= last && state == DATA;
      if (last && state == HDR) begin
        n <= word[IW-1:0];
        idx <= '0;
      end
      if (last && state == DATA) begin
        wr_addr <= 32'(idx) << 2;
        wr_data <= word;
        checksum <= checksum + word;
        idx <= idx + IW'(1);
      end
      done <= state_nxt == DONE;
      error <= state_nxt == ERR;
      cpu_rst <= state_nxt != DONE;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream stimulus checked every cycle against a frame-level model
module tb_imem_loader;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rst = 1'b1, byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready, wr_en, cpu_rst, done, error;
  logic [31:0] wr_addr, wr_data, checksum;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst(cpu_rst), .done(done), .error(error), .checksum(checksum)
  );
  logic [7:0] q[$];
  logic [63:0] wlog[$];
  longint k, n = 0;
  bit started = 0;
  logic m_wr_en = 0, m_done = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_sum = 0, w;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask
  function automatic logic [31:0] le(input longint i);
    return {q[i+3], q[i+2], q[i+1], q[i]};
  endfunction
  always @(posedge clk) begin
    started = 1;
    m_wr_en = 0;
    if (rst) begin
      q.delete();
      n = 0;
      m_addr = 0; m_data = 0; m_sum = 0; m_done = 0; m_err = 0;
    end else if (byte_valid && !m_done && !m_err) begin
      q.push_back(byte_data);
      k = q.size();
      if (k == 4) begin
        n = le(0);
        if (n > DEPTH) m_err = 1;
      end else if (k % 4 == 0 && k <= 4 + 4 * n) begin
        w = le(k - 4);
        m_wr_en = 1; m_addr = 32'(k - 8); m_data = w; m_sum += w;
      end else if (k == 8 + 4 * n) begin
        if (le(k - 4) == m_sum) m_done = 1; else m_err = 1;
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("byte_ready", 32'(byte_ready), 32'(!rst && !m_done && !m_err));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
    chk("checksum", checksum, m_sum);
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
    chk("cpu_rst", 32'(cpu_rst), 32'(!m_done));
    if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; byte_valid = 0;
    tick(); tick();
    rst = 0;
    wlog.delete();
  endtask
  task automatic send(input logic [7:0] b, input int gmax);
    repeat ($urandom_range(0, gmax)) tick();
    byte_valid = 1; byte_data = b;
    tick();
    byte_valid = 0;
  endtask
  task automatic send_word(input logic [31:0] v, input int gmax);
    for (int i = 0; i < 4; i++) send(8'(v >> (8 * i)), gmax);
  endtask
  task automatic idle(input int c);
    repeat (c) tick();
  endtask
  initial begin
    logic [31:0] s, r;
    int nn;
    do_reset();
    chk("rst cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst checksum", checksum, 32'd0);
    send_word(32'd2, 0); send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0); send_word(32'hF0E21567, 0);
    idle(2);
    chk("t1 checksum", checksum, 32'hF0E21567);
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1 byte_ready", 32'(byte_ready), 32'd0);
    chk("t1 nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t1 w0", wlog[0][31:0], 32'h12345678); chk("t1 a0", wlog[0][63:32], 32'h0);
      chk("t1 w1", wlog[1][31:0], 32'hDEADBEEF); chk("t1 a1", wlog[1][63:32], 32'h4);
    end
    do_reset();
    send_word(32'd2, 0); send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0); send_word(32'h0, 0);
    send_word(32'h11223344, 0);
    idle(2);
    chk("t2 error", 32'(error), 32'd1);
    chk("t2 done", 32'(done), 32'd0);
    chk("t2 cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t2 nwrites", 32'(wlog.size()), 32'd2);
    do_reset();
    send_word(32'd0, 0); send_word(32'd0, 0);
    idle(2);
    chk("t3 done", 32'(done), 32'd1);
    chk("t3 cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t3 nwrites", 32'(wlog.size()), 32'd0);
    do_reset();
    send_word(32'h00000401, 0);
    chk("t4 error", 32'(error), 32'd1);
    send_word(32'h12345678, 0); send_word(32'h0, 0);
    chk("t4 nwrites", 32'(wlog.size()), 32'd0);
    do_reset();
    send_word(32'd2, 5); send_word(32'hFFFFFFFF, 5); send_word(32'h2, 5); send_word(32'h1, 5);
    idle(2);
    chk("t5 checksum", checksum, 32'h1);
    chk("t5 done", 32'(done), 32'd1);
    chk("t5 nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t5 w0", wlog[0][31:0], 32'hFFFFFFFF); chk("t5 a1", wlog[1][63:32], 32'h4);
    end
    do_reset();
    send_word(32'd2, 0); send_word(32'h12345678, 0); send(8'hEF, 0); send(8'hBE, 0);
    rst = 1; wlog.delete();
    idle(3);
    rst = 0;
    idle(2);
    chk("t6 nwrites after rst", 32'(wlog.size()), 32'd0);
    send_word(32'd2, 0); send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0); send_word(32'hF0E21567, 0);
    idle(2);
    chk("t6 done", 32'(done), 32'd1);
    chk("t6 nwrites", 32'(wlog.size()), 32'd2);
    do_reset();
    send_word(32'(DEPTH), 0);
    s = 0;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom; s += r; send_word(r, 0);
    end
    send_word(s, 0);
    idle(2);
    chk("full done", 32'(done), 32'd1);
    chk("full nwrites", 32'(wlog.size()), 32'(DEPTH));
    if (wlog.size() > 0) chk("full last addr", wlog[$][63:32], 32'((DEPTH - 1) * 4));
    for (int f = 0; f < 25; f++) begin
      do_reset();
      nn = $urandom_range(0, 6);
      send_word(32'(nn), 3);
      s = 0;
      for (int i = 0; i < nn; i++) begin
        r = $urandom; s += r; send_word(r, 3);
      end
      send_word($urandom_range(0, 2) == 0 ? s ^ 32'h1 : s, 3);
      send_word($urandom, 2);
      idle(2);
      chk("rand nwrites", 32'(wlog.size()), 32'(nn));
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory over a byte-stream link. Accepts a framed byte stream (word count, payload words, checksum), assembles little-endian 32-bit words, and drives the instruction memory's write port with incrementing word-aligned addresses. Holds the CPU in reset until a frame has been loaded and its checksum verified. Sits between the host byte receiver and the write port of the RAM-backed instruction memory.

## Interface
Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; maximum loadable word count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  incoming stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs on a rising edge with byte_valid && byte_ready.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  32  byte address of the write (word index × 4, bits [1:0] = 0).
- wr_data  out  32  word to write.
- cpu_rst  out  1  CPU reset request; high until a successful load.
- done  out  1  frame loaded and checksum matched (sticky).
- error  out  1  frame rejected (sticky until rst).
- checksum  out  32  running mod-2^32 sum of payload words written so far.

## Operation
- Frame: 4-byte word count N (little-endian), then N×4 payload bytes, then 4-byte checksum C (little-endian). Each word: first byte → [7:0], fourth → [31:24].
- States: HDR, DATA, CSUM, DONE, ERR. Reset → HDR.
- HDR: collect 4 bytes into N. On the 4th byte: N > DEPTH → ERR; N == 0 → CSUM; else → DATA with word index 0.
- DATA: collect 4 bytes per word. On the 4th byte of each word: register wr_data = assembled word, wr_addr = index×4, pulse wr_en; checksum += word (wraps mod 2^32); index++. After word N-1 → CSUM.
- CSUM: collect 4 bytes. On the 4th: C == checksum (including that cycle's final update, already committed) → DONE, else → ERR.
- DONE: byte_ready=0, done=1, cpu_rst=0. Stays until rst.
- ERR: byte_ready=0, error=1, cpu_rst=1. No further writes. Stays until rst.
- byte_ready = 1 exactly in HDR, DATA, CSUM and when rst is low; combinational from state.
- Byte-within-word counter 0..3, cleared on every state change. Stalls (byte_valid low) of any length keep all state unchanged.
- Addresses never exceed (DEPTH-1)×4. The N > DEPTH check guarantees this.

## Timing
- Reset values (cycle after rst sampled high, and while held): state=HDR, byte_ready=0 while rst=1, wr_en=0, wr_addr=0, wr_data=0, checksum=0, done=0, error=0, cpu_rst=1.
- rst mid-frame: abandons the frame immediately. Issues no further wr_en. Restarts in HDR. Words already written are not undone.
- One byte per cycle max throughput. A word's wr_en is high in the cycle after the edge that accepted its 4th byte. wr_addr and wr_data are valid in that same cycle and held until the next write.
- State transitions take effect on the edge that accepts the deciding byte. byte_ready drops in the following cycle for DONE/ERR.
- done/error/cpu_rst are registered and change in the cycle after the deciding byte is accepted.
- checksum updates on the same edge as wr_en rises.

## Test plan
- Two-word load: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE, 67 15 E2 F0. Expected: wr_en pulses with (addr 0x0, data 0x12345678) then (addr 0x4, data 0xDEADBEEF); checksum=0xF0E21567; done=1, cpu_rst=0, byte_ready=0.
- Bad checksum: same frame with trailer 00 00 00 00. Expected: both writes occur; error=1, done=0, cpu_rst=1, byte_ready=0; further bytes ignored.
- Empty frame: 00 00 00 00, 00 00 00 00. Expected: no wr_en; done=1, cpu_rst=0.
- Oversize: header 01 04 00 00 (N=1025, DEPTH=1024). Expected: error=1 in the cycle after the 4th byte; no wr_en ever.
- Wrap and stalls: N=2, words 0xFFFFFFFF and 0x00000002, trailer 01 00 00 00, with random byte_valid gaps of 0–5 cycles. Expected: checksum=0x00000001, done=1, writes identical to the no-gap run.
- Reset mid-DATA: assert rst after 6 payload bytes, then send the full two-word frame. Expected: no wr_en during or after rst until the new frame; the new frame completes normally with done=1.
